// File: rtl/ex_issue_fwd.sv
// ex_issue_fwd: ID/EX issue register with ALU forwarding select
// and the EX/WB result register; writeback back-pressure freezes both.
module ex_issue_fwd (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] instr,
  output logic [2:0]  rf_ra1,
  output logic [2:0]  rf_ra2,
  input  logic [15:0] rf_rd1,
  input  logic [15:0] rf_rd2,
  output logic [15:0] alu_ain,
  output logic [15:0] alu_bin,
  output logic [1:0]  alu_op,
  output logic [1:0]  alu_select,
  output logic [15:0] alu_exout,
  input  logic [15:0] alu_result,
  output logic        wb_valid,
  output logic [2:0]  wb_rd,
  output logic [15:0] wb_data,
  input  logic        wb_ready
);

  logic        ex_valid_q, ex_valid_d;
  logic [2:0]  ex_rd_q, ex_rd_d;
  logic [15:0] ain_q, ain_d;
  logic [15:0] bin_q, bin_d;
  logic [1:0]  op_q, op_d;
  logic [1:0]  sel_q, sel_d;
  logic        wb_valid_q, wb_valid_d;
  logic [2:0]  wb_rd_q, wb_rd_d;
  logic [15:0] wb_data_q, wb_data_d;

  logic        adv;
  logic [1:0]  i_op;
  logic [2:0]  i_rd;
  logic        issue;
  logic [16:0] src1;
  logic [16:0] src2;
  logic        unused_bits;

  assign i_op   = instr[15:14];
  assign i_rd   = instr[11:9];
  assign rf_ra1 = instr[8:6];
  assign rf_ra2 = instr[5:3];
  assign unused_bits = ^{instr[13:12], instr[2:0]};

  assign adv      = !wb_valid_q || wb_ready;
  assign in_ready = adv;
  assign issue    = in_valid && (i_op == 2'b01 || i_op == 2'b10)
                    && (i_rd != 3'd0);

  // {select bit, operand}; EX match beats WB match beats register file
  function automatic logic [16:0] pick(input logic [2:0]  rs,
                                       input logic [15:0] rfd);
    logic [16:0] r;
    if (rs == 3'd0)
      r = 17'd0;
    else if (ex_valid_q && ex_rd_q == rs)
      r = {1'b1, 16'd0};
    else if (wb_valid_q && wb_rd_q == rs)
      r = {1'b0, wb_data_q};
    else
      r = {1'b0, rfd};
    return r;
  endfunction

  assign src1 = pick(rf_ra1, rf_rd1);
  assign src2 = pick(rf_ra2, rf_rd2);

  // next state: both stages advance together or hold together
  always_comb begin
    ex_valid_d = ex_valid_q;
    ex_rd_d    = ex_rd_q;
    ain_d      = ain_q;
    bin_d      = bin_q;
    op_d       = op_q;
    sel_d      = sel_q;
    wb_valid_d = wb_valid_q;
    wb_rd_d    = wb_rd_q;
    wb_data_d  = wb_data_q;
    if (adv) begin
      wb_valid_d = ex_valid_q;
      wb_rd_d    = ex_rd_q;
      wb_data_d  = alu_result;
      if (issue) begin
        ex_valid_d = 1'b1;
        ex_rd_d    = i_rd;
        ain_d      = src1[15:0];
        bin_d      = src2[15:0];
        op_d       = i_op;
        sel_d      = {src1[16], src2[16]};
      end else begin
        ex_valid_d = 1'b0;
        ex_rd_d    = 3'd0;
        ain_d      = 16'd0;
        bin_d      = 16'd0;
        op_d       = 2'b01;
        sel_d      = 2'b00;
      end
    end
  end

  // pipeline registers, cleared asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid_q <= 1'b0;
      ex_rd_q    <= 3'd0;
      ain_q      <= 16'd0;
      bin_q      <= 16'd0;
      op_q       <= 2'b01;
      sel_q      <= 2'b00;
      wb_valid_q <= 1'b0;
      wb_rd_q    <= 3'd0;
      wb_data_q  <= 16'd0;
    end else begin
      ex_valid_q <= ex_valid_d;
      ex_rd_q    <= ex_rd_d;
      ain_q      <= ain_d;
      bin_q      <= bin_d;
      op_q       <= op_d;
      sel_q      <= sel_d;
      wb_valid_q <= wb_valid_d;
      wb_rd_q    <= wb_rd_d;
      wb_data_q  <= wb_data_d;
    end
  end

  assign alu_ain    = ain_q;
  assign alu_bin    = bin_q;
  assign alu_op     = op_q;
  assign alu_select = sel_q;
  assign alu_exout  = wb_data_q;
  assign wb_valid   = wb_valid_q;
  assign wb_rd      = wb_rd_q;
  assign wb_data    = wb_data_q;

endmodule
